// File: rtl/cpu_branch_predictor.sv
// cpu_branch_predictor: direct-mapped BTB with saturating direction counters, zero-latency lookup.
// Optional statistics counters are built when CPU_BPRED_STATS_EN is defined.
module cpu_branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lookup_valid,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_branch,
    input  logic            upd_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    input  logic            flush,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_mispredicts
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = XLEN - IDX_BITS - 2;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));

    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  jump_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0] l_idx, u_idx;
    logic [TAG_BITS-1:0] l_tag, u_tag;
    logic                upd_en, upd_hit;
    logic [CTR_BITS-1:0] ctr_cur, ctr_d;
    logic                unused_bits;

    assign l_idx = lookup_pc[IDX_BITS+1:2];
    assign l_tag = lookup_pc[XLEN-1:IDX_BITS+2];
    assign u_idx = upd_pc[IDX_BITS+1:2];
    assign u_tag = upd_pc[XLEN-1:IDX_BITS+2];
    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign pred_taken  = pred_hit && (jump_q[l_idx] || ctr_q[l_idx][CTR_BITS-1]);
    assign pred_target = pred_hit ? target_q[l_idx] : '0;

    assign upd_en  = upd_valid && (upd_branch || upd_jump);
    assign upd_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign ctr_cur = ctr_q[u_idx];

    // Saturating counter step; never wraps at either end.
    always_comb begin
        ctr_d = ctr_cur;
        if (upd_taken && ctr_cur != '1)
            ctr_d = ctr_cur + CTR_BITS'(1);
        else if (!upd_taken && ctr_cur != '0)
            ctr_d = ctr_cur - CTR_BITS'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            jump_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (upd_en) begin
            if (upd_hit) begin
                if (!upd_jump)
                    ctr_q[u_idx] <= ctr_d;
                if (upd_taken)
                    target_q[u_idx] <= upd_target;
                jump_q[u_idx] <= upd_jump;
            end else if (upd_taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target;
                jump_q[u_idx]   <= upd_jump;
                ctr_q[u_idx]    <= upd_jump ? '1 : CTR_WT;
            end
        end
    end

`ifdef CPU_BPRED_STATS_EN
    logic [31:0] lookups_q, lookups_d, mispred_q, mispred_d;

    assign lookups_d = lookups_q + 32'(lookup_valid);
    assign mispred_d = mispred_q + 32'(upd_valid && upd_mispredict);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            lookups_q <= lookups_d;
            mispred_q <= mispred_d;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispred_q;
`else
    logic unused_stats;
    assign unused_stats     = lookup_valid ^ upd_mispredict;
    assign stat_lookups     = '0;
    assign stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_cpu_branch_predictor.sv
// tb_cpu_branch_predictor: directed checks of BTB lookup, training, aliasing, flush and stats.
module tb_cpu_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n, lookup_valid, upd_valid, upd_branch, upd_jump, upd_taken, upd_mispredict, flush;
    logic [31:0] lookup_pc, upd_pc, upd_target, pred_target, stat_lookups, stat_mispredicts;
    logic        pred_hit, pred_taken;
    int          n_chk = 0;
    int          n_fail = 0;

    cpu_branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_branch(upd_branch), .upd_jump(upd_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush(flush), .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic br, input logic jp,
                           input logic tk, input logic [31:0] tgt);
        upd_valid = 1'b1; upd_pc = pc; upd_branch = br; upd_jump = jp;
        upd_taken = tk; upd_target = tgt;
    endtask

    task automatic clr_upd();
        upd_valid = 1'b0; upd_branch = 1'b0; upd_jump = 1'b0; upd_taken = 1'b0;
        upd_mispredict = 1'b0; flush = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic br, input logic jp,
                       input logic tk, input logic [31:0] tgt);
        set_upd(pc, br, jp, tk, tgt);
        tick();
        clr_upd();
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_pc = pc;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; lookup_valid = 1'b0; lookup_pc = 32'h100;
        upd_pc = '0; upd_target = '0;
        clr_upd();
        #1;
        chk("reset_hit", {31'd0, pred_hit}, 32'd0);
        chk("reset_taken", {31'd0, pred_taken}, 32'd0);
        chk("reset_target", pred_target, 32'd0);
        #12 rst_n = 1'b1;
        tick();

        upd(32'h100, 1, 0, 1, 32'h80);
        look(32'h100);
        chk("alloc_hit", {31'd0, pred_hit}, 32'd1);
        chk("alloc_taken", {31'd0, pred_taken}, 32'd1);
        chk("alloc_target", pred_target, 32'h80);
        upd(32'h100, 1, 0, 0, 32'h0); #1;
        chk("dec1_taken", {31'd0, pred_taken}, 32'd0);
        chk("dec1_hit", {31'd0, pred_hit}, 32'd1);
        upd(32'h100, 1, 0, 0, 32'h0);
        upd(32'h100, 1, 0, 0, 32'h0); #1;
        chk("sat0_taken", {31'd0, pred_taken}, 32'd0);
        upd(32'h100, 1, 0, 1, 32'h80); #1;
        chk("inc1_taken", {31'd0, pred_taken}, 32'd0);
        upd(32'h100, 1, 0, 1, 32'h80);
        upd(32'h100, 1, 0, 1, 32'h80);
        upd(32'h100, 1, 0, 1, 32'h90);
        upd(32'h100, 1, 0, 0, 32'hAA); #1;
        chk("sat3_taken", {31'd0, pred_taken}, 32'd1);
        chk("retarget", pred_target, 32'h90);

        upd(32'h140, 0, 1, 1, 32'h200);
        look(32'h100);
        chk("alias_old_hit", {31'd0, pred_hit}, 32'd0);
        chk("alias_old_target", pred_target, 32'd0);
        look(32'h140);
        chk("alias_new_hit", {31'd0, pred_hit}, 32'd1);
        chk("alias_new_taken", {31'd0, pred_taken}, 32'd1);
        chk("alias_new_target", pred_target, 32'h200);

        upd(32'h180, 0, 0, 1, 32'h44);
        look(32'h180);
        chk("noflag_ignored", {31'd0, pred_hit}, 32'd0);
        upd(32'h300, 1, 0, 0, 32'h55);
        look(32'h300);
        chk("nt_miss_hit", {31'd0, pred_hit}, 32'd0);
        look(32'h140);
        chk("nt_miss_keep", pred_target, 32'h200);

        upd(32'h100, 1, 0, 1, 32'h80);
        set_upd(32'h104, 1, 0, 1, 32'h88);
        flush = 1'b1;
        tick();
        clr_upd();
        look(32'h100);
        chk("flush_100", {31'd0, pred_hit}, 32'd0);
        look(32'h104);
        chk("flush_104", {31'd0, pred_hit}, 32'd0);

        look(32'h180);
        set_upd(32'h180, 1, 0, 1, 32'h44);
        #1;
        chk("bypass_none", {31'd0, pred_hit}, 32'd0);
        tick();
        clr_upd();
        #1;
        chk("post_alloc_hit", {31'd0, pred_hit}, 32'd1);
        chk("post_alloc_tgt", pred_target, 32'h44);

        set_upd(32'h1C4, 1, 0, 1, 32'h66);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        clr_upd();
        rst_n = 1'b1;
        look(32'h180);
        chk("rst_clear_180", {31'd0, pred_hit}, 32'd0);
        look(32'h1C4);
        chk("rst_drop_1c4", {31'd0, pred_hit}, 32'd0);

        lookup_valid = 1'b1;
        repeat (5) tick();
        lookup_valid = 1'b0;
        upd_valid = 1'b1; upd_mispredict = 1'b1;
        repeat (2) tick();
        clr_upd();
`ifdef CPU_BPRED_STATS_EN
        chk("stat_lookups", stat_lookups, 32'd5);
        chk("stat_mispred", stat_mispredicts, 32'd2);
        force dut.lookups_q = 32'hFFFF_FFFF;
        #1;
        release dut.lookups_q;
        lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
        chk("stat_wrap", stat_lookups, 32'd0);
`else
        chk("stat_lookups_off", stat_lookups, 32'd0);
        chk("stat_mispred_off", stat_mispredicts, 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
